lane_serializer: RTL
====================

# lane_serializer

Downstream consumer of the packed port bundle: a 1-bit flag `foo`, an 8-bit lane-enable mask `bar`, and an 8×42-bit lane array `baz`. It accepts one bundle per handshake and emits the enabled `baz` lanes one per beat, in ascending lane order, on a 42-bit valid/ready stream tagged with lane index and end-of-packet. It sits directly after the non-ANSI port-expression stage and turns its wide parallel word into a narrow stream for the next pipeline stage.

## Interface
Parameters:
- NUM_LANES, 8, number of lanes in `baz` and bits in `bar`; power of two, ≥2
- LANE_WIDTH, 42, width of one `baz` lane

Ports:
- clk_i  input  1  sole clock, rising edge
- rst_ni  input  1  reset, synchronous, active-low
- in_valid_i  input  1  input bundle valid
- in_ready_o  output  1  block can accept a bundle
- in_foo_i  input  1  end-of-packet flag for this bundle
- in_bar_i  input  NUM_LANES  lane-enable mask; bit i enables lane i
- in_baz_i  input  NUM_LANES×LANE_WIDTH  packed lane array, lane i = in_baz_i[i]
- out_valid_o  output  1  output beat valid
- out_ready_i  input  1  downstream accepts beat
- out_data_o  output  LANE_WIDTH  lane payload
- out_lane_o  output  log2(NUM_LANES)  index of emitted lane
- out_last_o  output  1  final beat of a bundle whose foo was 1
- drop_o  output  1  one-cycle pulse: bundle with all-zero mask was accepted and discarded

## Operation
- One clock, clk_i; reset is synchronous, active-low on rst_ni. All state updates on rising edge of clk_i.
- Two-state FSM: IDLE, SHIFT.
- IDLE: in_ready_o=1. On in_valid_i && in_ready_o (accept), capture foo, mask, and full lane array into registers.
  - Mask ≠ 0 → SHIFT.
  - Mask = 0 → stay IDLE, pulse drop_o the next cycle, emit nothing; foo is discarded.
- SHIFT: in_ready_o=0. out_valid_o=1; out_lane_o = index of the lowest set bit of the remaining mask; out_data_o = captured lane at that index.
  - out_last_o = captured foo && (exactly one bit remains set).
- Beat transfer: out_valid_o && out_ready_i → clear that mask bit.
  - If the mask becomes 0 → IDLE.
  - Otherwise stay in SHIFT and present the next lowest lane the following cycle.
- While out_ready_i=0, out_valid_o, out_data_o, out_lane_o and out_last_o hold stable (no retraction, no change).
- Input fields are ignored when not accepted; captured data is immune to input changes after acceptance.
- Reset (rst_ni=0 at an edge), including mid-SHIFT:
  - FSM → IDLE; mask and foo registers cleared.
  - out_valid_o=0, out_last_o=0, drop_o=0, out_data_o=0, out_lane_o=0.
  - A partially emitted bundle is abandoned.
- in_ready_o is forced 0 while rst_ni=0, and is 1 from the first edge with rst_ni=1.

## Timing
- Accept at edge N → first beat visible (out_valid_o=1) after edge N, i.e. in cycle N+1; registered outputs, no combinational in→out path.
- k enabled lanes with out_ready_i held 1: beats in cycles N+1..N+k; in_ready_o returns to 1 in cycle N+k+1.
  - Throughput is one bundle per k+1 cycles.
- Zero-mask bundle: drop_o=1 in cycle N+1 only; in_ready_o stays 1, so back-to-back zero-mask bundles each pulse drop_o.
- out_ready_i stalls add cycles one-for-one; no beat lost or duplicated.
- in_ready_o depends only on FSM state (no combinational dependence on out_ready_i).

## Test plan
- Reset, then accept foo=1, bar=8'b1000_0101, baz[0]=42'h1, baz[2]=42'h2A, baz[7]=42'h3FF_FFFF_FFFF, with out_ready_i=1.
  - Required: three beats in consecutive cycles: lanes 0, 2, 7 with data 1, 0x2A, 0x3FFFFFFFFFF.
  - out_last_o=1 only on lane 7; in_ready_o=1 the cycle after.
- Same bundle with foo=0 → identical beats; out_last_o never asserts.
- bar=8'hFF, baz[i]=i+1, out_ready_i toggling 1,0,0,1,...
  - Required: eight beats, lanes 0..7, data 1..8.
  - Outputs stable during every stall cycle.
  - Input bundle changed after accept has no effect.
- Two back-to-back bundles with bar=8'h00 (foo=1) → drop_o pulses one cycle each, out_valid_o stays 0, in_ready_o stays 1.
- bar=8'h80, foo=1 → single beat, lane 7, out_last_o=1; ready low for exactly one cycle with out_ready_i=1.
- Mid-packet reset: bar=8'hF0, assert rst_ni=0 after the first beat.
  - Required: next cycle out_valid_o=0 and in_ready_o=0.
  - After release, in_ready_o=1 and no residual beats appear.

Source files
------------

// File: rtl/lane_serializer_if.sv
// Bundle-in / lane-stream-out port group for lane_serializer.
// The DUT uses the slave modport; the producer/consumer side uses master.
interface lane_serializer_if #(
  parameter int unsigned NUM_LANES  = 8,
  parameter int unsigned LANE_WIDTH = 42
);
  localparam int unsigned LANE_IDX_W = $clog2(NUM_LANES);

  logic                                  in_valid_i;
  logic                                  in_ready_o;
  logic                                  in_foo_i;
  logic [NUM_LANES-1:0]                  in_bar_i;
  logic [NUM_LANES-1:0][LANE_WIDTH-1:0]  in_baz_i;
  logic                                  out_valid_o;
  logic                                  out_ready_i;
  logic [LANE_WIDTH-1:0]                 out_data_o;
  logic [LANE_IDX_W-1:0]                 out_lane_o;
  logic                                  out_last_o;
  logic                                  drop_o;

  modport slave (
    input  in_valid_i, in_foo_i, in_bar_i, in_baz_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_lane_o, out_last_o, drop_o
  );

  modport master (
    output in_valid_i, in_foo_i, in_bar_i, in_baz_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_lane_o, out_last_o, drop_o
  );
endinterface

// File: rtl/lane_serializer.sv
// Captures one {foo, bar, baz} bundle and streams its enabled baz lanes,
// lowest index first, one per beat on a valid/ready stream.
module lane_serializer #(
  parameter int unsigned NUM_LANES  = 8,
  parameter int unsigned LANE_WIDTH = 42
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  lane_serializer_if.slave  bus
);
  localparam int unsigned LANE_IDX_W = $clog2(NUM_LANES);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e                                state_q, state_d;
  logic [NUM_LANES-1:0]                  mask_q, mask_d;
  logic                                  foo_q, foo_d;
  logic [NUM_LANES-1:0][LANE_WIDTH-1:0]  lanes_q, lanes_d;
  logic                                  in_ready_q;
  logic                                  out_valid_q;
  logic [LANE_WIDTH-1:0]                 out_data_q;
  logic [LANE_IDX_W-1:0]                 out_lane_q;
  logic                                  out_last_q;
  logic                                  drop_q;

  logic                                  accept;
  logic                                  beat_done;
  logic                                  drop_d;
  logic [LANE_IDX_W-1:0]                 lane_d;
  logic                                  last_d;

  assign accept    = bus.in_valid_i && in_ready_q;
  assign beat_done = out_valid_q && bus.out_ready_i;

  // Next mask/capture: load on accept, retire the lowest lane on each transfer.
  always_comb begin
    mask_d  = mask_q;
    foo_d   = foo_q;
    lanes_d = lanes_q;
    drop_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          mask_d  = bus.in_bar_i;
          foo_d   = bus.in_foo_i && (bus.in_bar_i != '0);
          lanes_d = bus.in_baz_i;
          drop_d  = (bus.in_bar_i == '0);
        end
      end
      SHIFT: begin
        if (beat_done) begin
          mask_d = mask_q & (mask_q - NUM_LANES'(1));
        end
      end
      default: ;
    endcase
    state_d = (mask_d != '0) ? SHIFT : IDLE;
  end

  // Lowest set bit of the next mask selects the lane presented next cycle.
  always_comb begin
    lane_d = '0;
    for (int unsigned i = NUM_LANES; i > 0; i--) begin
      if (mask_d[i-1]) begin
        lane_d = LANE_IDX_W'(i - 1);
      end
    end
    last_d = foo_d && (mask_d != '0) && ((mask_d & (mask_d - NUM_LANES'(1))) == '0);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      foo_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_lane_q  <= '0;
      out_last_q  <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      foo_q       <= foo_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == SHIFT);
      out_data_q  <= (mask_d != '0) ? lanes_d[lane_d] : '0;
      out_lane_q  <= lane_d;
      out_last_q  <= last_d;
      drop_q      <= drop_d;
    end
  end

  // Lane payload store; only meaningful while the mask is non-zero.
  always_ff @(posedge clk_i) begin
    lanes_q <= lanes_d;
  end

  assign bus.in_ready_o  = in_ready_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_data_o  = out_data_q;
  assign bus.out_lane_o  = out_lane_q;
  assign bus.out_last_o  = out_last_q;
  assign bus.drop_o      = drop_q;
endmodule
